// File: rtl/first_nios2_system_irq_pkg.sv
// Shared definitions for the Nios II interrupt aggregator: register addresses,
// FSM encoding and the upper bound on the number of source lines.
package first_nios2_system_irq_pkg;

  localparam int unsigned IRQ_MAX = 16;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_FORCE   = 3'd4;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd5;
  localparam logic [2:0] ADDR_STATE   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } irq_state_e;

endpackage

// File: rtl/first_nios2_system_irq_prio_enc.sv
// Combinational priority encoder: the lowest set request bit wins.
module first_nios2_system_irq_prio_enc
  import first_nios2_system_irq_pkg::*;
(
  input  logic [IRQ_MAX-1:0] req_i,
  output logic               valid_o,
  output logic [3:0]         index_o
);

  // Scanning from the top down lets the lowest index overwrite the rest.
  always_comb begin
    valid_o = 1'b0;
    index_o = 4'd0;
    for (int i = IRQ_MAX - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        index_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/first_nios2_system_irq_aggregator.sv
// Interrupt aggregator for the Nios II CPU: pending/mask/edge registers,
// assert/holdoff FSM driving a registered irq, and an Avalon register file.
module first_nios2_system_irq_aggregator
  import first_nios2_system_irq_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, edge_q, irqInDly_q;
  logic [NUM_IRQ-1:0] wrData, riseEvt, forceSet, w1cClr, edgeNext;
  logic [15:0]        holdoff_q, count_q, count_d;
  logic [15:0]        readdata_q, readdata_d;
  logic [IRQ_MAX-1:0] pendingExt, maskExt, edgeExt;
  irq_state_e         state_q, state_d;
  logic               irq_q;
  logic               wrEn, wrPending, wrMask, wrEdge, wrForce, wrHoldoff;
  logic               active;
  logic [3:0]         prioIdx;

  assign wrEn      = chipselect && !write_n;
  assign wrPending = wrEn && (address == ADDR_PENDING);
  assign wrMask    = wrEn && (address == ADDR_MASK);
  assign wrEdge    = wrEn && (address == ADDR_EDGE);
  assign wrForce   = wrEn && (address == ADDR_FORCE);
  assign wrHoldoff = wrEn && (address == ADDR_HOLDOFF);
  assign wrData    = writedata[NUM_IRQ-1:0];

  // Edge bits: a new set (rise or FORCE) beats a same-cycle W1C. Level bits track the line.
  assign riseEvt   = irq_in & ~irqInDly_q;
  assign forceSet  = wrForce ? wrData : '0;
  assign w1cClr    = wrPending ? wrData : '0;
  assign edgeNext  = riseEvt | forceSet | (pending_q & ~w1cClr);
  assign pending_d = (edge_q & edgeNext) | (~edge_q & irq_in);

  always_comb begin
    pendingExt = '0;
    maskExt    = '0;
    edgeExt    = '0;
    pendingExt[NUM_IRQ-1:0] = pending_q;
    maskExt[NUM_IRQ-1:0]    = mask_q;
    edgeExt[NUM_IRQ-1:0]    = edge_q;
  end

  first_nios2_system_irq_prio_enc u_prio_enc (
    .req_i   (pendingExt & maskExt),
    .valid_o (active),
    .index_o (prioIdx)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (active) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!active) begin
          if (holdoff_q == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            count_d = holdoff_q;
          end
        end
      end
      ST_HOLDOFF: begin
        count_d = count_q - 16'd1;
        if (count_q <= 16'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    readdata_d = 16'h0000;
    case (address)
      ADDR_PENDING: readdata_d = pendingExt;
      ADDR_MASK:    readdata_d = maskExt;
      ADDR_EDGE:    readdata_d = edgeExt;
      ADDR_ACTIVE:  readdata_d = {active, 11'b0, prioIdx};
      ADDR_HOLDOFF: readdata_d = holdoff_q;
      ADDR_STATE:   readdata_d = {14'b0, state_q};
      default:      readdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      irqInDly_q <= '0;
      holdoff_q  <= 16'd0;
      count_q    <= 16'd0;
      readdata_q <= 16'd0;
      state_q    <= ST_IDLE;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      irqInDly_q <= irq_in;
      count_q    <= count_d;
      readdata_q <= readdata_d;
      state_q    <= state_d;
      irq_q      <= (state_d == ST_ASSERT);
      if (wrMask)    mask_q    <= wrData;
      if (wrEdge)    edge_q    <= wrData;
      if (wrHoldoff) holdoff_q <= writedata;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_first_nios2_system_irq_aggregator.sv
// Self-checking bench for the interrupt aggregator: register reads are scored
// through an expected-value queue, irq timing is checked cycle by cycle.
module tb_first_nios2_system_irq_aggregator;
  import first_nios2_system_irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [15:0] irq_in;
  logic        irq;

  int checkCount = 0;
  int errorCount = 0;

  logic [15:0] expQ[$];
  string       tagQ[$];

  first_nios2_system_irq_aggregator #(.NUM_IRQ(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] lines);
    irq_in = lines;
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [15:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input string tag, input logic [2:0] addr, input logic [15:0] expected);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    expQ.push_back(expected);
    tagQ.push_back(tag);
    tick();
    chipselect = 1'b0;
    checkOutput(tagQ.pop_front(), readdata, expQ.pop_front());
  endtask

  task automatic checkIrq(input string tag, input logic expected);
    checkOutput(tag, {15'b0, irq}, {15'b0, expected});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0000;
    irq_in     = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state: every address reads zero, irq low
    checkIrq("rst_irq", 1'b0);
    for (int a = 0; a < 8; a++) begin
      readReg($sformatf("rst_rd%0d", a), 3'(a), 16'h0000);
    end

    // Edge source 0: one-cycle pulse, two-edge latency, W1C deassert
    writeReg(ADDR_MASK, 16'h0001);
    writeReg(ADDR_EDGE, 16'h0001);
    applyStimulus(16'h0001);
    tick();
    applyStimulus(16'h0000);
    checkIrq("edge_irq_e1", 1'b0);
    tick();
    checkIrq("edge_irq_e2", 1'b1);
    readReg("edge_active", ADDR_ACTIVE, 16'h8000);
    readReg("edge_pending", ADDR_PENDING, 16'h0001);
    writeReg(ADDR_PENDING, 16'h0001);
    checkIrq("w1c_irq_same", 1'b1);
    tick();
    checkIrq("w1c_irq_fall", 1'b0);

    // Level sources 4 and 5
    writeReg(ADDR_MASK, 16'h0030);
    writeReg(ADDR_EDGE, 16'h0000);
    applyStimulus(16'h0030);
    tick();
    checkIrq("lvl_irq_e1", 1'b0);
    tick();
    checkIrq("lvl_irq_e2", 1'b1);
    readReg("lvl_active45", ADDR_ACTIVE, 16'h8004);
    writeReg(ADDR_PENDING, 16'h0030);
    readReg("lvl_w1c_noeff", ADDR_PENDING, 16'h0030);
    applyStimulus(16'h0020);
    tick();
    readReg("lvl_active5", ADDR_ACTIVE, 16'h8005);
    applyStimulus(16'h0000);
    tick();
    checkIrq("lvl_drop_same", 1'b1);
    tick();
    checkIrq("lvl_drop_fall", 1'b0);

    // Holdoff of 10 cycles on edge source 3, new edge during the gap
    writeReg(ADDR_HOLDOFF, 16'd10);
    writeReg(ADDR_MASK, 16'h0008);
    writeReg(ADDR_EDGE, 16'h0008);
    applyStimulus(16'h0008);
    tick();
    applyStimulus(16'h0000);
    tick();
    checkIrq("ho_assert", 1'b1);
    writeReg(ADDR_PENDING, 16'h0008);
    tick();
    checkIrq("ho_gap1", 1'b0);
    applyStimulus(16'h0008);
    tick();
    applyStimulus(16'h0000);
    checkIrq("ho_gap2", 1'b0);
    readReg("ho_state", ADDR_STATE, 16'h0002);
    for (int k = 3; k <= 10; k++) begin
      tick();
      checkIrq($sformatf("ho_gap%0d", k), 1'b0);
    end
    tick();
    checkIrq("ho_reassert", 1'b1);

    // Edge on bit 2 coinciding with its W1C: the set wins
    writeReg(ADDR_EDGE, 16'h000C);
    applyStimulus(16'h0004);
    writeReg(ADDR_PENDING, 16'h0004);
    applyStimulus(16'h0000);
    readReg("setwins_pending", ADDR_PENDING, 16'h000C);
    writeReg(ADDR_HOLDOFF, 16'd0);
    writeReg(ADDR_PENDING, 16'h000C);
    checkIrq("clr_same", 1'b1);
    tick();
    checkIrq("clr_fall", 1'b0);

    // FORCE on an edge-mode, enabled bit
    writeReg(ADDR_FORCE, 16'h0008);
    checkIrq("force_e0", 1'b0);
    tick();
    checkIrq("force_e1", 1'b1);
    readReg("force_rd0", ADDR_FORCE, 16'h0000);

    // Clearing MASK deasserts like a W1C; restoring it reasserts
    writeReg(ADDR_MASK, 16'h0000);
    checkIrq("mask_same", 1'b1);
    tick();
    checkIrq("mask_fall", 1'b0);
    writeReg(ADDR_MASK, 16'h0008);
    tick();
    checkIrq("mask_restore", 1'b1);

    // Asynchronous reset in the middle of a holdoff
    writeReg(ADDR_HOLDOFF, 16'd5);
    writeReg(ADDR_PENDING, 16'h0008);
    tick();
    checkIrq("rst_ho_low", 1'b0);
    readReg("rst_ho_state", ADDR_STATE, 16'h0002);
    #2;
    reset_n = 1'b0;
    #1;
    checkIrq("async_irq", 1'b0);
    checkOutput("async_readdata", readdata, 16'h0000);
    tick();
    reset_n = 1'b1;
    readReg("post_state", ADDR_STATE, 16'h0000);
    readReg("post_pending", ADDR_PENDING, 16'h0000);
    readReg("post_mask", ADDR_MASK, 16'h0000);
    readReg("post_holdoff", ADDR_HOLDOFF, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
